// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with registered in_ready.
// Handshake: a transfer happens only at a rising edge where valid=1 and ready=1 on the same side.
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             pop;

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = main_q;
    assign count    = state;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !pop)      state_nxt = FULL;
                else if (pop && !accept) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready and out_valid are registered from the next state so both are
    // glitch-free flop outputs yet still track count in the same cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            case (state)
                EMPTY: if (accept) main_q <= in_data;
                ONE: begin
                    if (accept && pop)  main_q <= in_data;
                    else if (accept)    skid_q <= in_data;
                end
                FULL:  if (pop) main_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, backpressure, flush, async reset.
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [1:0]   count;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    pipe_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] c, input logic v, input logic r);
        chk({tag, "_count"}, W'(count), W'(c));
        chk({tag, "_out_valid"}, W'(out_valid), W'(v));
        chk({tag, "_in_ready"}, W'(in_ready), W'(r));
    endtask

    initial begin
        // reset held, then released between edges with a producer already waiting
        #1;
        chk_state("rst", 2'd0, 1'b0, 1'b0);
        chk("rst_out_data", out_data, '0);
        drive(1'b1, 32'hA5A5_A5A5, 1'b0);
        repeat (2) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        chk_state("rel_pre_edge", 2'd0, 1'b0, 1'b0);
        tick();
        chk_state("rel_edge1", 2'd0, 1'b0, 1'b1);
        tick();
        chk_state("rel_accept", 2'd1, 1'b1, 1'b1);
        chk("rel_data", out_data, 32'hA5A5_A5A5);
        drive(1'b0, '0, 1'b1);
        tick();
        chk_state("rel_drain", 2'd0, 1'b0, 1'b1);

        // streaming at full rate
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, W'(i), 1'b1);
            exp_q.push_back(W'(i));
            tick();
            exp_v = exp_q.pop_front();
            chk($sformatf("stream_data_%0d", i), out_data, exp_v);
            chk_state($sformatf("stream_%0d", i), 2'd1, 1'b1, 1'b1);
        end
        drive(1'b0, '0, 1'b1);
        tick();
        chk_state("stream_end", 2'd0, 1'b0, 1'b1);

        // backpressure fills both entries, then drains with no gap
        drive(1'b1, 32'h11, 1'b0);
        tick();
        chk_state("bp_one", 2'd1, 1'b1, 1'b1);
        drive(1'b1, 32'h22, 1'b0);
        tick();
        chk_state("bp_full", 2'd2, 1'b1, 1'b0);
        chk("bp_full_data", out_data, 32'h11);
        drive(1'b1, 32'h33, 1'b0);
        tick();
        chk_state("bp_hold", 2'd2, 1'b1, 1'b0);
        chk("bp_hold_data", out_data, 32'h11);
        drive(1'b1, 32'h33, 1'b1);
        tick();
        chk_state("bp_pop1", 2'd1, 1'b1, 1'b1);
        chk("bp_pop1_data", out_data, 32'h22);
        tick();
        chk_state("bp_pop2", 2'd1, 1'b1, 1'b1);
        chk("bp_pop2_data", out_data, 32'h33);
        drive(1'b0, '0, 1'b1);
        tick();
        chk_state("bp_empty", 2'd0, 1'b0, 1'b1);

        // flush while FULL with a simultaneous accept and pop
        drive(1'b1, 32'h11, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b0);
        tick();
        chk_state("fl_full", 2'd2, 1'b1, 1'b0);
        drive(1'b1, 32'h44, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_state("fl_after", 2'd0, 1'b0, 1'b1);
        chk("fl_data", out_data, '0);
        drive(1'b0, '0, 1'b0);
        tick();
        chk_state("fl_settle", 2'd0, 1'b0, 1'b1);
        chk("fl_settle_data", out_data, '0);

        // idle handshake lines leave a held entry alone
        drive(1'b1, 32'h55, 1'b0);
        tick();
        drive(1'b0, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(1'b0, 32'h1234_5678, 1'b0);
        tick();
        chk_state("idle", 2'd1, 1'b1, 1'b1);
        chk("idle_data", out_data, 32'h55);
        drive(1'b0, '0, 1'b1);
        tick();
        chk_state("idle_drain", 2'd0, 1'b0, 1'b1);

        // async reset between edges while FULL
        drive(1'b1, 32'h11, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b0);
        tick();
        chk_state("ar_full", 2'd2, 1'b1, 1'b0);
        drive(1'b1, 32'h66, 1'b1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk_state("ar_now", 2'd0, 1'b0, 1'b0);
        chk("ar_data", out_data, '0);
        #1 clr = 1'b1;
        tick();
        chk_state("ar_rel", 2'd0, 1'b0, 1'b1);
        chk("ar_rel_data", out_data, '0);
        drive(1'b0, '0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
